// File: rtl/demux_pkg.sv
// Shared types and defaults for the 1-to-16 demux driver path.
// State encodings, mode encodings and default select/dwell sizing.
package demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_SCAN  = 1'b0;
  localparam logic MODE_ROUTE = 1'b1;

  localparam int SEL_W_DEF = 4;
  localparam int N_OUT_DEF = 2 ** SEL_W_DEF;
  localparam int DWELL_DEF = 4;

endpackage

// File: rtl/dwell_counter.sv
// Down-counter timing how long one select value is held; load wins over decrement.
// zero_o flags the final cycle of a dwell.
module dwell_counter #(
  parameter int unsigned DWELL = 4,
  parameter int          W     = $clog2(DWELL) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = W'(DWELL - 1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/demux_sel_sequencer.sv
// Drives data bit and select of the 1-to-16 demux: full sweep (SCAN) or single
// handshaked request (ROUTE), each channel held DWELL cycles, then a done pulse.
module demux_sel_sequencer
  import demux_pkg::*;
#(
  parameter int unsigned DWELL = DWELL_DEF,
  parameter int          SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             start,
  input  logic             scan_bit,
  input  logic             abort,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_sel,
  input  logic             req_bit,
  output logic             dmx_in,
  output logic [SEL_W-1:0] dmx_sel,
  output logic             dmx_en,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W    = $clog2(DWELL) + 1;
  localparam logic [SEL_W-1:0] LAST_SEL = {SEL_W{1'b1}};

  state_t           state_q, state_d;
  logic             route_q, route_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             din_q, din_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             xfer;

  dwell_counter #(
    .DWELL (DWELL),
    .W     (CNT_W)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  // A handshake is honoured even if mode dropped in the same cycle.
  assign xfer = (state_q == ST_IDLE) && req_valid && ready_q;

  always_comb begin
    state_d  = state_q;
    route_d  = route_q;
    sel_d    = sel_q;
    din_d    = din_q;
    en_d     = en_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        en_d   = 1'b0;
        din_d  = 1'b0;
        busy_d = 1'b0;
        if (xfer) begin
          state_d  = ST_HOLD;
          route_d  = 1'b1;
          sel_d    = req_sel;
          din_d    = req_bit;
          en_d     = 1'b1;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
        end else if (start && (mode == MODE_SCAN)) begin
          state_d  = ST_HOLD;
          route_d  = 1'b0;
          sel_d    = '0;
          din_d    = scan_bit;
          en_d     = 1'b1;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
        end
      end

      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          din_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_zero) begin
          if (!route_q && (sel_q != LAST_SEL)) begin
            // Step to the next channel back-to-back; data bit is kept.
            sel_d    = sel_q + 1'b1;
            cnt_load = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            en_d    = 1'b0;
            din_d   = 1'b0;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        din_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    ready_d = (state_d == ST_IDLE) && (mode == MODE_ROUTE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      route_q <= 1'b0;
      sel_q   <= '0;
      din_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      sel_q   <= sel_d;
      din_q   <= din_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign dmx_in    = din_q;
  assign dmx_sel   = sel_q;
  assign dmx_en    = en_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Directed bench: sequencer feeding a 1-to-16 demux; demux output checked against hand-computed one-hot values.
module tb_demux_sel_sequencer;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        start;
  logic        scan_bit;
  logic        abort;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_sel;
  logic        req_bit;
  logic        dmx_in;
  logic [3:0]  dmx_sel;
  logic        dmx_en;
  logic        busy;
  logic        done;
  logic [15:0] o;

  int n_chk = 0;
  int n_err = 0;

  demux_sel_sequencer #(.DWELL(4), .SEL_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .start     (start),
    .scan_bit  (scan_bit),
    .abort     (abort),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_bit   (req_bit),
    .dmx_in    (dmx_in),
    .dmx_sel   (dmx_sel),
    .dmx_en    (dmx_en),
    .busy      (busy),
    .done      (done)
  );

  // 1-to-16 demux stage: routes dmx_in onto output dmx_sel.
  always_comb begin
    o = 16'h0000;
    o[dmx_sel] = dmx_in;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [3:0] sels [3];
  logic       bits [3];
  int         xc   [3];

  initial begin
    int idx;
    int nd;
    int got;
    sels = '{4'h3, 4'h7, 4'hC};
    bits = '{1'b1, 1'b0, 1'b1};
    xc   = '{0, 0, 0};

    rst_n = 1'b0; mode = 1'b0; start = 1'b0; scan_bit = 1'b0; abort = 1'b0;
    req_valid = 1'b0; req_sel = 4'h0; req_bit = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outs", 32'({dmx_en, busy, done, req_ready, dmx_in}), 32'h0);
    chk("rst_sel", 32'(dmx_sel), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready_scan", 32'(req_ready), 32'h0);

    // 1: full sweep, one-hot walk 0x0001..0x8000, done at T+65
    scan_bit = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      if (k > 1) @(negedge clk);
      chk("s1_sel", 32'(dmx_sel), 32'((k - 1) / 4));
      chk("s1_o", 32'(o), 32'h1 << ((k - 1) / 4));
      chk("s1_flags", 32'({dmx_en, busy, done}), 32'b110);
    end
    @(negedge clk);
    chk("s1_done_flags", 32'({dmx_en, busy, done}), 32'b001);
    chk("s1_done_o", 32'(o), 32'h0);
    chk("s1_done_sel", 32'(dmx_sel), 32'hF);
    @(negedge clk);
    chk("s1_done_pulse", 32'(done), 32'h0);

    // 2: single route to channel 10
    mode = 1'b1;
    @(negedge clk);
    chk("s2_ready", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_sel = 4'hA; req_bit = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("s2_ready_low", 32'(req_ready), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      chk("s2_o", 32'(o), 32'h0400);
      chk("s2_flags", 32'({dmx_en, busy, done}), 32'b110);
    end
    @(negedge clk);
    chk("s2_done", 32'({dmx_en, busy, done, req_ready}), 32'b0010);
    @(negedge clk);
    chk("s2_ready_back", 32'({req_ready, done}), 32'b10);

    // 3: three back-to-back requests with valid held high
    idx = 0; nd = 0; got = 0;
    req_sel = sels[0]; req_bit = bits[0]; req_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) @(negedge clk);
      if (got != 0) begin
        chk("s3_sel", 32'(dmx_sel), 32'(sels[idx-1]));
        chk("s3_bit", 32'({dmx_en, dmx_in}), 32'({1'b1, bits[idx-1]}));
        got = 0;
        if (idx < 3) begin
          req_sel = sels[idx]; req_bit = bits[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (done) nd++;
      if (req_valid && req_ready && idx < 3) begin
        xc[idx] = n; idx++; got = 1;
      end
    end
    chk("s3_count", 32'(idx), 32'd3);
    chk("s3_gap01", 32'(xc[1] - xc[0]), 32'd6);
    chk("s3_gap12", 32'(xc[2] - xc[1]), 32'd6);
    chk("s3_dones", 32'(nd), 32'd3);

    // 4: abort at channel 5
    mode = 1'b0; start = 1'b1; scan_bit = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (21) @(negedge clk);
    chk("s4_sel5", 32'(dmx_sel), 32'h5);
    chk("s4_o5", 32'(o), 32'h0020);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("s4_flags", 32'({dmx_en, busy, done}), 32'b000);
    chk("s4_o", 32'(o), 32'h0);
    nd = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("s4_no_done", 32'(nd), 32'd0);

    // 5: async reset mid-sweep at channel 7
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    chk("s5_sel7", 32'(dmx_sel), 32'h7);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_async_flags", 32'({dmx_en, busy, done, req_ready, dmx_in}), 32'h0);
    chk("s5_async_sel", 32'(dmx_sel), 32'h0);
    chk("s5_async_o", 32'(o), 32'h0);
    mode = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("s5_ready_pre", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("s5_ready_post", 32'({req_ready, busy, done}), 32'b100);

    // 6: input disturbances while busy must not alter the sweep
    mode = 1'b0; start = 1'b1; scan_bit = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      if (k > 1) @(negedge clk);
      chk("s6_sel", 32'(dmx_sel), 32'((k - 1) / 4));
      chk("s6_o", 32'(o), 32'h1 << ((k - 1) / 4));
      chk("s6_flags", 32'({dmx_en, busy, done, req_ready}), 32'b1100);
      mode      = (k >= 10 && k <= 20) ? k[0] : 1'b0;
      start     = (k == 30);
      req_valid = (k >= 40 && k <= 42);
      req_sel   = 4'h3;
      req_bit   = 1'b1;
    end
    @(negedge clk);
    chk("s6_done", 32'({dmx_en, busy, done}), 32'b001);
    mode = 1'b1;
    @(negedge clk);
    chk("s6_ready", 32'(req_ready), 32'h1);
    mode = 1'b0; start = 1'b1; req_valid = 1'b1; req_sel = 4'h9; req_bit = 1'b1;
    @(negedge clk);
    start = 1'b0; req_valid = 1'b0;
    chk("s6_route_sel", 32'(dmx_sel), 32'h9);
    chk("s6_route_o", 32'(o), 32'h0200);
    repeat (3) @(negedge clk);
    chk("s6_route_hold", 32'(o), 32'h0200);
    @(negedge clk);
    chk("s6_route_done", 32'({dmx_en, done}), 32'b01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
